// File: rtl/keystone_coord_scheduler.sv
// rtl/keystone_coord_scheduler.sv - Keystone homography per-frame coordinate request scheduler
//
// Purpose:
//   At start of frame, latches the eight homography coefficients into a
//   frame-stable shadow set. Then issues destination-pixel (x,y) requests in
//   raster order over a valid/ready handshake. A credit counter bounds the
//   number of in-flight calculations. When every result of the frame has come
//   back, frame_done pulses for one cycle.
//
// Optional feature:
//   KEYSTONE_SCHED_PERF_EN - when defined, builds the stall_cycles performance
//   counter. When undefined, stall_cycles is tied to zero.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   aclken               clock enable; when low, all state and outputs freeze
//   sw_reset             synchronous soft reset; has priority over all other events
//   enable_keystone      0 loads the identity matrix instead of the h*_in values
//   frame_start          SOF beat accepted on the input video stream
//   h11_in..h32_in       coefficients from the register file (Q8.24)
//   h11_out..h32_out     shadow coefficients sent to the datapath
//   req_valid/req_ready  request handshake
//   req_x/req_y          request coordinate
//   req_eol/req_eof      request is the last pixel of its line / of the frame
//   rsp_valid            one datapath result retired
//   busy                 scheduler is not idle
//   frame_done           one-cycle pulse when the frame is fully retired
//   err_sof              sticky: frame_start seen outside IDLE
//   err_underflow        sticky: rsp_valid seen with no request in flight
//   stall_cycles         count of RUN cycles that were stalled or credit-blocked

module keystone_coord_scheduler #(
  parameter int FRAME_WIDTH     = 1280,
  parameter int FRAME_HEIGHT    = 720,
  parameter int MAX_OUTSTANDING = 8,
  parameter int COEF_W          = 32,
  parameter int X_W             = 11,
  parameter int Y_W             = 10
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              aclken,
  input  logic              sw_reset,
  input  logic              enable_keystone,
  input  logic              frame_start,
  input  logic [COEF_W-1:0] h11_in,
  input  logic [COEF_W-1:0] h12_in,
  input  logic [COEF_W-1:0] h13_in,
  input  logic [COEF_W-1:0] h21_in,
  input  logic [COEF_W-1:0] h22_in,
  input  logic [COEF_W-1:0] h23_in,
  input  logic [COEF_W-1:0] h31_in,
  input  logic [COEF_W-1:0] h32_in,
  output logic [COEF_W-1:0] h11_out,
  output logic [COEF_W-1:0] h12_out,
  output logic [COEF_W-1:0] h13_out,
  output logic [COEF_W-1:0] h21_out,
  output logic [COEF_W-1:0] h22_out,
  output logic [COEF_W-1:0] h23_out,
  output logic [COEF_W-1:0] h31_out,
  output logic [COEF_W-1:0] h32_out,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [X_W-1:0]    req_x,
  output logic [Y_W-1:0]    req_y,
  output logic              req_eol,
  output logic              req_eof,
  input  logic              rsp_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              err_sof,
  output logic              err_underflow,
  output logic [31:0]       stall_cycles
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] MAX_O  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [X_W-1:0]   X_LAST = X_W'(FRAME_WIDTH - 1);
  localparam logic [Y_W-1:0]   Y_LAST = Y_W'(FRAME_HEIGHT - 1);
  localparam logic [COEF_W-1:0] C_ONE  = COEF_W'(32'h0100_0000);
  localparam logic [COEF_W-1:0] C_ZERO = '0;
  // Packed coefficient order, index 0..7: h11 h12 h13 h21 h22 h23 h31 h32.
  localparam logic [7:0][COEF_W-1:0] IDENT =
    {C_ZERO, C_ZERO, C_ZERO, C_ONE, C_ZERO, C_ZERO, C_ZERO, C_ONE};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

  state_t                    state;
  logic [OUT_W-1:0]          outstanding;
  logic [7:0][COEF_W-1:0]    shadow;
  logic [7:0][COEF_W-1:0]    h_in_pk;

  logic                      hs;
  logic                      rsp_ok;
  logic [OUT_W-1:0]          out_nxt;
  logic                      credit_nxt;
  logic [X_W-1:0]            x_adv;
  logic [Y_W-1:0]            y_adv;
  logic                      eol_adv;
  logic                      eof_adv;

  assign h_in_pk = {h32_in, h31_in, h23_in, h22_in, h21_in, h13_in, h12_in, h11_in};

  assign h11_out = shadow[0];
  assign h12_out = shadow[1];
  assign h13_out = shadow[2];
  assign h21_out = shadow[3];
  assign h22_out = shadow[4];
  assign h23_out = shadow[5];
  assign h31_out = shadow[6];
  assign h32_out = shadow[7];

  // req_valid is only ever high in RUN, so the handshake alone is enough to
  // qualify coordinate advancement.
  always_comb begin
    hs      = req_valid & req_ready;
    // A response with nothing in flight is dropped so the credit count can never wrap.
    rsp_ok  = rsp_valid & (outstanding != '0);
    out_nxt = outstanding;
    if (hs && !rsp_ok)
      out_nxt = outstanding + OUT_W'(1);
    else if (!hs && rsp_ok)
      out_nxt = outstanding - OUT_W'(1);
    credit_nxt = (out_nxt < MAX_O);

    x_adv = req_x + X_W'(1);
    y_adv = req_y;
    if (req_x == X_LAST) begin
      x_adv = '0;
      y_adv = req_y + Y_W'(1);
    end
    eol_adv = (x_adv == X_LAST);
    eof_adv = eol_adv & (y_adv == Y_LAST);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      outstanding   <= '0;
      shadow        <= IDENT;
      req_valid     <= 1'b0;
      req_x         <= '0;
      req_y         <= '0;
      req_eol       <= 1'b0;
      req_eof       <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      err_sof       <= 1'b0;
      err_underflow <= 1'b0;
    end else if (aclken) begin
      if (sw_reset) begin
        state         <= S_IDLE;
        outstanding   <= '0;
        shadow        <= IDENT;
        req_valid     <= 1'b0;
        req_x         <= '0;
        req_y         <= '0;
        req_eol       <= 1'b0;
        req_eof       <= 1'b0;
        busy          <= 1'b0;
        frame_done    <= 1'b0;
        err_sof       <= 1'b0;
        err_underflow <= 1'b0;
      end else begin
        frame_done  <= 1'b0;
        outstanding <= out_nxt;
        if (rsp_valid && (outstanding == '0))
          err_underflow <= 1'b1;
        // A SOF outside IDLE is dropped rather than queued; the current frame runs on.
        if (frame_start && (state != S_IDLE))
          err_sof <= 1'b1;

        case (state)
          S_IDLE: begin
            if (frame_start) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            shadow    <= enable_keystone ? h_in_pk : IDENT;
            req_x     <= '0;
            req_y     <= '0;
            req_eol   <= (X_LAST == '0);
            req_eof   <= (X_LAST == '0) && (Y_LAST == '0);
            req_valid <= credit_nxt;
            state     <= S_RUN;
          end
          S_RUN: begin
            if (hs && req_eof) begin
              // Coordinates stay on the final pixel; nothing more is issued this frame.
              req_valid <= 1'b0;
              state     <= S_DRAIN;
            end else begin
              if (hs) begin
                req_x   <= x_adv;
                req_y   <= y_adv;
                req_eol <= eol_adv;
                req_eof <= eof_adv;
              end
              // Without a handshake out_nxt never grows, so an asserted
              // request cannot drop before it has been accepted.
              req_valid <= credit_nxt;
            end
          end
          S_DRAIN: begin
            if (outstanding == '0) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef KEYSTONE_SCHED_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stall_q <= '0;
    end else if (aclken) begin
      if (sw_reset || (state == S_LOAD))
        stall_q <= '0;
      else if ((state == S_RUN) && (!req_valid || !req_ready) && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
